multiplier_pp_param: RTL and testbench

MULTIPLIER_PP_PARAM -- requirements
Module: multiplier_pp_param

---
 rtl/multiplier_pp_param_pkg.sv | 20 ++
 rtl/multiplier_pp_param_leaf.sv | 21 ++
 rtl/multiplier_pp_param.sv | 113 +++++++++++
 tb/tb_multiplier_pp_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pp_param_pkg.sv
// Shared constants for the partial-product multiplier family.
// Provides the ceiling log2 used to size the adder tree and the resulting
// pipeline latency: three fixed stages (operand, partial product, negate)
// plus two tree levels per doubling of the chunk count.
package multiplier_pp_param_pkg;

  function automatic int unsigned log2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned lat_f(input int unsigned width, input int unsigned leaf);
    return 3 + 2 * log2_f(width / leaf);
  endfunction

endpackage

// File: rtl/multiplier_pp_param_leaf.sv
// multiplier_pp_leaf: registered LEAF x LEAF unsigned product.
// Ports: iClk clock, iRst sync active-high reset, iEn load enable,
//        iClr sync flush, iA/iB operands, oP registered 2*LEAF-bit product.
module multiplier_pp_leaf #(
  parameter int unsigned LEAF = 32
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iClr,
  input  logic [LEAF-1:0]   iA,
  input  logic [LEAF-1:0]   iB,
  output logic [2*LEAF-1:0] oP
);

  always_ff @(posedge iClk) begin
    if (iRst || iClr) oP <= '0;
    else if (iEn)     oP <= {{LEAF{1'b0}}, iA} * {{LEAF{1'b0}}, iB};
  end

endmodule

// File: rtl/multiplier_pp_param.sv
// multiplier_pp_param: pipelined WIDTH x WIDTH multiplier built from K*K
// LEAF-wide partial products summed by a registered binary adder tree.
// Signed operands are converted to magnitudes up front and the product is
// negated in the final stage. Global stall: every stage moves on advance.
// Ports: iClk clock, iRst sync active-high reset, iEn advance enable,
//        iClr sync flush, iValid/oReady operand handshake, iSigned operand
//        mode, iData0/iData1 operands, oValid/iReady result handshake,
//        oData 2*WIDTH-bit product.
module multiplier_pp_param
  import multiplier_pp_param_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned LEAF  = 32
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iEn,
  input  logic               iClr,
  input  logic               iValid,
  output logic               oReady,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iData0,
  input  logic [WIDTH-1:0]   iData1,
  output logic               oValid,
  input  logic               iReady,
  output logic [2*WIDTH-1:0] oData
);

  localparam int unsigned K   = WIDTH / LEAF;
  localparam int unsigned N   = K * K;
  localparam int unsigned LAT = lat_f(WIDTH, LEAF);
  localparam int unsigned PW  = 2 * WIDTH;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] abs0, abs1;
  logic             neg_in;
  logic [WIDTH-1:0] mag0, mag1;
  logic [LAT-1:0]   vld;
  logic [LAT-2:0]   sgn;
  logic [PW-1:0]    root;

  logic [2*LEAF-1:0] pp   [0:N-1];
  logic [PW-1:0]     term [0:N-1];

  assign advance = iEn & (~oValid | iReady);
  assign oReady  = advance & ~iClr & ~iRst;
  assign accept  = iValid & oReady;
  assign oValid  = vld[LAT-1];

  always_comb begin
    abs0   = (iSigned & iData0[WIDTH-1]) ? -iData0 : iData0;
    abs1   = (iSigned & iData1[WIDTH-1]) ? -iData1 : iData1;
    neg_in = iSigned & (iData0[WIDTH-1] ^ iData1[WIDTH-1]);
  end

  // Operand stage, valid/sign shift chains and final negation stage.
  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      mag0  <= '0;
      mag1  <= '0;
      vld   <= '0;
      sgn   <= '0;
      oData <= '0;
    end else if (advance) begin
      mag0  <= abs0;
      mag1  <= abs1;
      vld   <= {vld[LAT-2:0], accept};
      sgn   <= {sgn[LAT-3:0], neg_in};
      oData <= sgn[LAT-2] ? -root : root;
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      multiplier_pp_leaf #(.LEAF(LEAF)) u_leaf (
        .iClk (iClk),
        .iRst (iRst),
        .iEn  (advance),
        .iClr (iClr),
        .iA   (mag0[i*LEAF +: LEAF]),
        .iB   (mag1[j*LEAF +: LEAF]),
        .oP   (pp[i*K+j])
      );
      assign term[i*K+j] = PW'(pp[i*K+j]) << ((i + j) * LEAF);
    end
  end

  // Tree laid out as a heap: node n sums children 2n and 2n+1; indices
  // N..2N-1 are the shifted partial products, so every leaf sits at the same
  // depth and each heap level is one registered tree level.
  if (N > 1) begin : g_tree
    logic [PW-1:0] node [1:N-1];
    for (genvar n = 1; n < N; n++) begin : g_node
      logic [PW-1:0] lhs, rhs;
      if (2 * n >= N) begin : g_leafs
        assign lhs = term[2*n - N];
        assign rhs = term[2*n + 1 - N];
      end else begin : g_inner
        assign lhs = node[2*n];
        assign rhs = node[2*n + 1];
      end
      always_ff @(posedge iClk) begin
        if (iRst || iClr) node[n] <= '0;
        else if (advance) node[n] <= lhs + rhs;
      end
    end
    assign root = node[1];
  end else begin : g_flat
    assign root = term[0];
  end

endmodule

// File: tb/tb_multiplier_pp_param.sv
module tb_multiplier_pp_param;

  localparam int unsigned W   = 128;
  localparam int unsigned LAT = 7;
  localparam int unsigned SW  = 32;
  localparam int unsigned SLAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           iRst, iEn, iClr, iValid, iSigned, iReady;
  logic [W-1:0]   iData0, iData1;
  logic           oReady, oValid;
  logic [2*W-1:0] oData;

  logic            s_iValid, s_iSigned;
  logic [SW-1:0]   s_iData0, s_iData1;
  logic            s_oReady, s_oValid;
  logic [2*SW-1:0] s_oData;

  multiplier_pp_param #(.WIDTH(128), .LEAF(32)) u_dut (
    .iClk(clk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
    .iValid(iValid), .oReady(oReady), .iSigned(iSigned),
    .iData0(iData0), .iData1(iData1),
    .oValid(oValid), .iReady(iReady), .oData(oData)
  );

  multiplier_pp_param #(.WIDTH(32), .LEAF(32)) u_small (
    .iClk(clk), .iRst(iRst), .iEn(1'b1), .iClr(1'b0),
    .iValid(s_iValid), .oReady(s_oReady), .iSigned(s_iSigned),
    .iData0(s_iData0), .iData1(s_iData1),
    .oValid(s_oValid), .iReady(1'b1), .oData(s_oData)
  );

  int unsigned    total = 0;
  int unsigned    bad = 0;
  logic [255:0]   q[$];
  int             cyc = 0;
  int             last_cons = -10;
  int unsigned    run_len = 0;
  int unsigned    max_run = 0;
  int unsigned    ncons = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b, input logic s);
    logic [255:0] xa, xb;
    xa = s ? {{128{a[127]}}, a} : {128'b0, a};
    xb = s ? {{128{b[127]}}, b} : {128'b0, b};
    return xa * xb;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic new_operands();
    iData0  = {$urandom, $urandom, $urandom, $urandom};
    iData1  = {$urandom, $urandom, $urandom, $urandom};
    iSigned = 1'($urandom_range(0, 1));
  endtask

  // One clock with scoreboard bookkeeping of both handshakes.
  task automatic tick(input string tag, output logic acc);
    logic cons;
    #1;
    acc  = iValid && oReady;
    cons = oValid && iReady && iEn && !iClr && !iRst;
    if (cons) begin
      ncons++;
      if (q.size() == 0) check({tag, "_stale"}, {255'b0, oValid}, 256'b0);
      else               check(tag, oData, q.pop_front());
      if (cyc == last_cons + 1) run_len++;
      else                      run_len = 1;
      if (run_len > max_run) max_run = run_len;
      last_cons = cyc;
    end
    if (acc) q.push_back(ref_mul(iData0, iData1, iSigned));
    step();
  endtask

  task automatic run_one(input string tag, input logic [127:0] a, input logic [127:0] b,
                         input logic s, input logic [255:0] exp);
    iData0 = a; iData1 = b; iSigned = s; iValid = 1'b1;
    step();
    iValid = 1'b0;
    repeat (LAT - 2) step();
    check({tag, "_early"}, {255'b0, oValid}, 256'b0);
    step();
    check({tag, "_vld"}, {255'b0, oValid}, 256'b1);
    check(tag, oData, exp);
  endtask

  task automatic run_small(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp);
    s_iData0 = a; s_iData1 = b; s_iSigned = s; s_iValid = 1'b1;
    step();
    s_iValid = 1'b0;
    repeat (SLAT - 2) step();
    check({tag, "_early"}, {255'b0, s_oValid}, 256'b0);
    step();
    check({tag, "_vld"}, {255'b0, s_oValid}, 256'b1);
    check(tag, {192'b0, s_oData}, {192'b0, exp});
  endtask

  task automatic flush_test(input logic use_rst);
    logic acc;
    iReady = 1'b1; iValid = 1'b1; q.delete();
    for (int i = 0; i < 4; i++) begin
      tick("pre_flush", acc);
      if (acc) new_operands();
    end
    if (use_rst) iRst = 1'b1; else iClr = 1'b1;
    #1;
    check(use_rst ? "rst_ready" : "clr_ready", {255'b0, oReady}, 256'b0);
    tick("flush", acc);
    check(use_rst ? "rst_vld" : "clr_vld", {255'b0, oValid}, 256'b0);
    check(use_rst ? "rst_data" : "clr_data", oData, 256'b0);
    iRst = 1'b0; iClr = 1'b0; iValid = 1'b0;
    q.delete();
    #1;
    check(use_rst ? "rst_release_ready" : "clr_release_ready", {255'b0, oReady}, 256'b1);
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      tick("post_flush", acc);
      check(use_rst ? "rst_no_stale" : "clr_no_stale", {255'b0, oValid}, 256'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic         acc;
    logic [255:0] e;
    logic [255:0] held;
    int unsigned  sent;

    iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iValid = 1'b0; iSigned = 1'b0; iReady = 1'b1;
    iData0 = '0; iData1 = '0;
    s_iValid = 1'b0; s_iSigned = 1'b0; s_iData0 = '0; s_iData1 = '0;
    step(); step();
    check("rst_ready_low", {255'b0, oReady}, 256'b0);
    check("rst_ovalid", {255'b0, oValid}, 256'b0);
    check("rst_odata", oData, 256'b0);
    check("rst_small_ovalid", {255'b0, s_oValid}, 256'b0);
    iRst = 1'b0;
    #1;
    check("rst_ready_after", {255'b0, oReady}, 256'b1);

    // Directed 128-bit vectors
    run_one("umax", {128{1'b1}}, {128{1'b1}}, 1'b0,
            {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1});
    run_one("u_small", 128'd3, 128'd7, 1'b0, 256'd21);
    e = 256'h1 << 128;
    run_one("u_cross", 128'h1_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000, 1'b0, e);
    run_one("u_ones_x2", {128{1'b1}}, 128'd2, 1'b0, {127'b0, {128{1'b1}}, 1'b0});
    run_one("s_neg1x5", {128{1'b1}}, 128'd5, 1'b1, {{248{1'b1}}, 8'hFB});
    e = 256'h1 << 254;
    run_one("s_min_sq", {1'b1, 127'b0}, {1'b1, 127'b0}, 1'b1, e);
    run_one("s_minxmax", {1'b1, 127'b0}, {1'b0, {127{1'b1}}}, 1'b1, {2'b11, 126'b0, 1'b1, 127'b0});

    // Directed 32-bit (K=1) vectors
    run_small("k1_u_0xmax", 32'h0, 32'hFFFFFFFF, 1'b0, 64'h0);
    run_small("k1_u_maxsq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    run_small("k1_s_maxsq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1);
    run_small("k1_s_0xmax", 32'h0, 32'hFFFFFFFF, 1'b1, 64'h0);
    run_small("k1_s_min_sq", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    run_small("k1_s_neg1x3", 32'hFFFFFFFF, 32'h3, 1'b1, 64'hFFFFFFFF_FFFFFFFD);

    repeat (LAT) step();

    // Back-to-back stream of 20
    iReady = 1'b1; iValid = 1'b1; sent = 0; ncons = 0; max_run = 0; q.delete();
    new_operands();
    for (int c = 0; c < 40; c++) begin
      if (sent == 20) iValid = 1'b0;
      tick("stream", acc);
      if (acc) begin
        sent++;
        new_operands();
      end
    end
    check("stream_count", 256'(ncons), 256'd20);
    check("stream_run", 256'(max_run), 256'd20);
    check("stream_q_empty", 256'(q.size()), 256'd0);

    // Backpressure with full pipeline
    iReady = 1'b0; iValid = 1'b1; ncons = 0; q.delete();
    new_operands();
    for (int c = 0; c < 20 && !oValid; c++) begin
      tick("bp_fill", acc);
      if (acc) new_operands();
    end
    check("bp_filled", {255'b0, oValid}, 256'b1);
    check("bp_inflight", 256'(q.size()), 256'(LAT));
    held = oData;
    for (int c = 0; c < 5; c++) begin
      tick("bp_hold", acc);
      check("bp_ready", {255'b0, oReady}, 256'b0);
      check("bp_valid", {255'b0, oValid}, 256'b1);
      check("bp_data", oData, held);
    end
    iReady = 1'b1; iValid = 1'b0;
    for (int c = 0; c < 15; c++) tick("bp_drain", acc);
    check("bp_count", 256'(ncons), 256'(LAT));
    check("bp_q_empty", 256'(q.size()), 256'd0);

    // Enable freeze with a result at the output
    iValid = 1'b1; new_operands(); ncons = 0;
    tick("en_accept", acc);
    iValid = 1'b0;
    for (int c = 0; c < int'(LAT) - 1; c++) tick("en_run", acc);
    check("en_vld_before", {255'b0, oValid}, 256'b1);
    iEn = 1'b0;
    held = oData;
    for (int c = 0; c < 3; c++) begin
      tick("en_hold", acc);
      check("en_ready", {255'b0, oReady}, 256'b0);
      check("en_valid", {255'b0, oValid}, 256'b1);
      check("en_data", oData, held);
    end
    iEn = 1'b1;
    tick("en_resume", acc);
    check("en_count", 256'(ncons), 256'd1);

    flush_test(1'b0);
    flush_test(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
